exe_stage: RTL and testbench

Execute stage of the five-stage ARM pipeline: consumes the decoded bundle produced by `ID_STAGE`, owns the ID/EXE pipeline register, ALU, Val2 generator, status register (NZCV) and EX/MEM register. It is the producer end of the branch interface consumed by `IF_Stage`/`IF_Stage_Reg` (`branchTaken`, `branchAddress`) and of the `status` input consumed by `ID_STAGE` for condition checks. Results leave through the EX/MEM register toward the memory stage.

---
 rtl/exe_stage.sv | 177 +++++++++++++++++
 tb/tb_exe_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage ARM pipeline.
// Holds the ID/EXE register, the Val2 generator, the ALU, the NZCV status
// register and the EX/MEM register. It also resolves branches for the fetch
// stage.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   freeze                 holds every internal register (memory stall)
//   flush                  loads a bubble into the ID/EXE register
//   *_in                   decoded bundle coming from ID_STAGE
//   branchTaken/Address    branch resolution toward IF_Stage
//   status                 {N,Z,C,V}, used by ID_STAGE for condition checks
//   aluResult, valRm_out,
//   destination_out, *_out EX/MEM register contents toward the memory stage
module exe_stage #(
  parameter logic [3:0] STATUS_INIT = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] valRn_in,
  input  logic [31:0] valRm_in,
  input  logic [23:0] imm24_in,
  input  logic [11:0] shiftOperand_in,
  input  logic        imm_in,
  input  logic [3:0]  executionCommand_in,
  input  logic [3:0]  destination_in,
  input  logic        writebackEnabled_in,
  input  logic        memoryReadEnabled_in,
  input  logic        memoryWriteEnabled_in,
  input  logic        s_in,
  input  logic        b_in,
  output logic        branchTaken,
  output logic [31:0] branchAddress,
  output logic [3:0]  status,
  output logic [31:0] aluResult,
  output logic [31:0] valRm_out,
  output logic [3:0]  destination_out,
  output logic        writebackEnabled_out,
  output logic        memoryReadEnabled_out,
  output logic        memoryWriteEnabled_out
);

  // ID/EXE register
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [23:0] id_imm24;
  logic [11:0] id_shift_op;
  logic        id_imm, id_wb, id_mem_r, id_mem_w, id_s, id_b;
  logic [3:0]  id_cmd, id_dest;

  always_ff @(posedge clk) begin
    if (rst || (!freeze && flush)) begin
      id_pc       <= '0;
      id_val_rn   <= '0;
      id_val_rm   <= '0;
      id_imm24    <= '0;
      id_shift_op <= '0;
      id_imm      <= 1'b0;
      id_cmd      <= '0;
      id_dest     <= '0;
      id_wb       <= 1'b0;
      id_mem_r    <= 1'b0;
      id_mem_w    <= 1'b0;
      id_s        <= 1'b0;
      id_b        <= 1'b0;
    end else if (!freeze) begin
      id_pc       <= pc_in;
      id_val_rn   <= valRn_in;
      id_val_rm   <= valRm_in;
      id_imm24    <= imm24_in;
      id_shift_op <= shiftOperand_in;
      id_imm      <= imm_in;
      id_cmd      <= executionCommand_in;
      id_dest     <= destination_in;
      id_wb       <= writebackEnabled_in;
      id_mem_r    <= memoryReadEnabled_in;
      id_mem_w    <= memoryWriteEnabled_in;
      id_s        <= s_in;
      id_b        <= b_in;
    end
  end

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] d;
    d = {v, v} >> n;
    return d[31:0];
  endfunction

  // Val2 generator
  logic [31:0] val2;
  logic [4:0]  sh_amt;
  assign sh_amt = id_shift_op[11:7];

  always_comb begin
    val2 = '0;
    if (id_imm) begin
      val2 = ror32({24'b0, id_shift_op[7:0]}, {id_shift_op[11:8], 1'b0});
    end else if (id_mem_r || id_mem_w) begin
      val2 = {20'b0, id_shift_op};
    end else begin
      unique case (id_shift_op[6:5])
        2'b00:   val2 = id_val_rm << sh_amt;
        2'b01:   val2 = id_val_rm >> sh_amt;
        2'b10:   val2 = $signed(id_val_rm) >>> sh_amt;
        default: val2 = ror32(id_val_rm, sh_amt);
      endcase
    end
  end

  // ALU
  logic [32:0] sum;
  logic [31:0] result;
  logic        c_new, v_new, op_valid;

  always_comb begin
    sum      = '0;
    result   = '0;
    c_new    = status[1];
    v_new    = status[0];
    op_valid = 1'b1;
    unique case (id_cmd)
      4'b0001: result = val2;
      4'b1001: result = ~val2;
      4'b0010, 4'b0011: begin
        sum    = {1'b0, id_val_rn} + {1'b0, val2}
                 + {32'b0, (id_cmd[0] & status[1])};
        result = sum[31:0];
        c_new  = sum[32];
        v_new  = (id_val_rn[31] == val2[31]) && (result[31] != id_val_rn[31]);
      end
      4'b0100, 4'b0101: begin
        sum    = {1'b0, id_val_rn} - {1'b0, val2}
                 - {32'b0, (id_cmd[0] & ~status[1])};
        result = sum[31:0];
        c_new  = ~sum[32];  // carry means no borrow
        v_new  = (id_val_rn[31] != val2[31]) && (result[31] != id_val_rn[31]);
      end
      4'b0110: result = id_val_rn & val2;
      4'b0111: result = id_val_rn | val2;
      4'b1000: result = id_val_rn ^ val2;
      default: op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_INIT;
    end else if (!freeze && id_s && op_valid) begin
      status <= {result[31], (result == 32'b0), c_new, v_new};
    end
  end

  assign branchTaken   = id_b;
  assign branchAddress = id_pc + {{6{id_imm24[23]}}, id_imm24, 2'b00};

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      aluResult              <= '0;
      valRm_out              <= '0;
      destination_out        <= '0;
      writebackEnabled_out   <= 1'b0;
      memoryReadEnabled_out  <= 1'b0;
      memoryWriteEnabled_out <= 1'b0;
    end else if (!freeze) begin
      aluResult              <= result;
      valRm_out              <= id_val_rm;
      destination_out        <= id_dest;
      writebackEnabled_out   <= id_wb;
      memoryReadEnabled_out  <= id_mem_r;
      memoryWriteEnabled_out <= id_mem_w;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic [31:0] pc_in, valRn_in, valRm_in;
  logic [23:0] imm24_in;
  logic [11:0] shiftOperand_in;
  logic        imm_in;
  logic [3:0]  executionCommand_in, destination_in;
  logic        writebackEnabled_in, memoryReadEnabled_in, memoryWriteEnabled_in;
  logic        s_in, b_in;
  logic        branchTaken;
  logic [31:0] branchAddress;
  logic [3:0]  status;
  logic [31:0] aluResult, valRm_out;
  logic [3:0]  destination_out;
  logic        writebackEnabled_out, memoryReadEnabled_out, memoryWriteEnabled_out;

  int n_tests = 0;
  int n_fail  = 0;

  exe_stage #(.STATUS_INIT(4'b0000)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .valRn_in(valRn_in), .valRm_in(valRm_in),
    .imm24_in(imm24_in), .shiftOperand_in(shiftOperand_in), .imm_in(imm_in),
    .executionCommand_in(executionCommand_in), .destination_in(destination_in),
    .writebackEnabled_in(writebackEnabled_in),
    .memoryReadEnabled_in(memoryReadEnabled_in),
    .memoryWriteEnabled_in(memoryWriteEnabled_in),
    .s_in(s_in), .b_in(b_in),
    .branchTaken(branchTaken), .branchAddress(branchAddress), .status(status),
    .aluResult(aluResult), .valRm_out(valRm_out),
    .destination_out(destination_out),
    .writebackEnabled_out(writebackEnabled_out),
    .memoryReadEnabled_out(memoryReadEnabled_out),
    .memoryWriteEnabled_out(memoryWriteEnabled_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pc_in = '0; valRn_in = '0; valRm_in = '0; imm24_in = '0;
    shiftOperand_in = '0; imm_in = 1'b0; executionCommand_in = '0;
    destination_in = '0; writebackEnabled_in = 1'b0;
    memoryReadEnabled_in = 1'b0; memoryWriteEnabled_in = 1'b0;
    s_in = 1'b0; b_in = 1'b0;
  endtask

  task automatic bundle(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] sop, input logic i, input logic s);
    clear_inputs();
    executionCommand_in = cmd; valRn_in = rn; valRm_in = rm;
    shiftOperand_in = sop; imm_in = i; s_in = s;
  endtask

  // Issue one instruction, follow it with a bubble, check the registered result.
  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] rn,
                        input logic [31:0] rm, input logic [11:0] sop, input logic i,
                        input logic s, input logic [31:0] exp);
    bundle(cmd, rn, rm, sop, i, s);
    step();
    clear_inputs();
    step();
    chk(tag, aluResult, exp);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    clear_inputs();
    step(); step();
    chk("rst_alu",    aluResult, 32'h0);
    chk("rst_status", {28'b0, status}, 32'h0);
    chk("rst_btaken", {31'b0, branchTaken}, 32'h0);
    chk("rst_baddr",  branchAddress, 32'h0);
    chk("rst_ctrl",   {29'b0, writebackEnabled_out, memoryReadEnabled_out,
                       memoryWriteEnabled_out}, 32'h0);
    chk("rst_dest",   {28'b0, destination_out}, 32'h0);
    chk("rst_rm",     valRm_out, 32'h0);
    rst = 1'b0;

    // Arithmetic and flags
    run_op("add_s", 4'b0010, 32'h7FFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b1, 32'h8000_0000);
    chk("add_s_nzcv", {28'b0, status}, 32'h9);
    run_op("sub_s_eq", 4'b0100, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1, 32'h0);
    chk("sub_s_nzcv", {28'b0, status}, 32'h6);
    run_op("adc_c1", 4'b0011, 32'd1, 32'h0, 12'h001, 1'b1, 1'b0, 32'd3);
    chk("adc_nzcv_hold", {28'b0, status}, 32'h6);
    run_op("sbc_s_c1", 4'b0101, 32'd10, 32'd3, 12'h000, 1'b0, 1'b1, 32'd7);
    chk("sbc_s_nzcv", {28'b0, status}, 32'h2);
    run_op("sub_s_borrow", 4'b0100, 32'd3, 32'd10, 12'h000, 1'b0, 1'b1, 32'hFFFF_FFF9);
    chk("sub_borrow_nzcv", {28'b0, status}, 32'h8);
    run_op("sbc_c0", 4'b0101, 32'd10, 32'd3, 12'h000, 1'b0, 1'b0, 32'd6);

    // Shifter and logic
    run_op("mov_asr1",  4'b0001, 32'h0, 32'h8000_0001, 12'h0C0, 1'b0, 1'b0, 32'hC000_0000);
    run_op("mov_imm_rot", 4'b0001, 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 32'hFF00_0000);
    run_op("mov_ror4",  4'b0001, 32'h0, 32'h0000_00F1, 12'h260, 1'b0, 1'b0, 32'h1000_000F);
    run_op("mov_lsr31", 4'b0001, 32'h0, 32'h8000_0000, 12'hFA0, 1'b0, 1'b0, 32'h1);
    run_op("mov_lsl4",  4'b0001, 32'h0, 32'h0000_00F1, 12'h200, 1'b0, 1'b0, 32'h0000_0F10);
    run_op("mvn_imm0",  4'b1001, 32'h0, 32'h0, 12'h000, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_op("and", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 1'b0, 1'b0, 32'hF000_F000);
    run_op("orr", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 1'b0, 1'b0, 32'hFFF0_FFF0);
    run_op("eor", 4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 1'b0, 1'b0, 32'h0FF0_0FF0);
    run_op("undef_op", 4'b1111, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1, 32'h0);
    chk("undef_nzcv_hold", {28'b0, status}, 32'h8);

    // Memory address and store data
    bundle(4'b0010, 32'h100, 32'h1234_5678, 12'h00C, 1'b0, 1'b0);
    memoryReadEnabled_in = 1'b1; writebackEnabled_in = 1'b1; destination_in = 4'd2;
    step(); clear_inputs(); step();
    chk("ldr_addr", aluResult, 32'h10C);
    chk("ldr_memr", {30'b0, memoryReadEnabled_out, memoryWriteEnabled_out}, 32'h2);
    chk("ldr_wb_dest", {27'b0, writebackEnabled_out, destination_out}, 32'h12);
    bundle(4'b0010, 32'h200, 32'hCAFE_BABE, 12'hFFC, 1'b0, 1'b0);
    memoryWriteEnabled_in = 1'b1;
    step(); clear_inputs(); step();
    chk("str_addr", aluResult, 32'h11FC);
    chk("str_data", valRm_out, 32'hCAFE_BABE);
    chk("str_memw", {30'b0, memoryReadEnabled_out, memoryWriteEnabled_out}, 32'h1);

    // Branch, then flush the instruction behind it
    clear_inputs();
    pc_in = 32'h20; imm24_in = 24'hFFFFFE; b_in = 1'b1; destination_in = 4'hA;
    step();
    chk("br_taken", {31'b0, branchTaken}, 32'h1);
    chk("br_addr", branchAddress, 32'h18);
    bundle(4'b0001, 32'h0, 32'h0, 12'h055, 1'b1, 1'b0);
    writebackEnabled_in = 1'b1; destination_in = 4'd7;
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_inputs();
    chk("br_exmem_dest", {28'b0, destination_out}, 32'hA);
    chk("br_exmem_wb", {31'b0, writebackEnabled_out}, 32'h0);
    chk("flush_btaken", {31'b0, branchTaken}, 32'h0);
    step();
    chk("flushed_mov_alu", aluResult, 32'h0);
    chk("flushed_mov_wb", {27'b0, writebackEnabled_out, destination_out}, 32'h0);

    // Freeze during a flag-setting ADD
    bundle(4'b0001, 32'h0, 32'h0, 12'h055, 1'b1, 1'b0);
    writebackEnabled_in = 1'b1; destination_in = 4'd1;
    step();
    bundle(4'b0010, 32'hFFFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b1);
    step();
    freeze = 1'b1;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      step();
      chk("frz_alu", aluResult, 32'h55);
      chk("frz_status", {28'b0, status}, 32'h8);
    end
    flush = 1'b0;
    freeze = 1'b0;
    step();
    chk("unfrz_alu", aluResult, 32'h0);
    chk("unfrz_status", {28'b0, status}, 32'h6);
    chk("unfrz_dest", {28'b0, destination_out}, 32'h0);
    step();
    chk("after_unfrz_status", {28'b0, status}, 32'h6);

    // Reset wins over freeze mid-operation
    bundle(4'b0001, 32'h0, 32'h0, 12'h0AA, 1'b1, 1'b1);
    writebackEnabled_in = 1'b1; b_in = 1'b1; destination_in = 4'd9;
    step(); clear_inputs(); step();
    chk("pre_rst_alu", aluResult, 32'hAA);
    rst = 1'b1; freeze = 1'b1;
    step();
    chk("rst_frz_alu", aluResult, 32'h0);
    chk("rst_frz_status", {28'b0, status}, 32'h0);
    chk("rst_frz_wb", {27'b0, writebackEnabled_out, destination_out}, 32'h0);
    rst = 1'b0; freeze = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
